// File: rtl/prog_loader.sv
// Program loader: encodes instruction fields from a valid/ready stream into
// 9-bit words and writes them to consecutive instruction-memory addresses.
module prog_loader #(
    parameter int IW = 9,
    parameter int AW = 10
) (
    input  logic          CLK,
    input  logic          Reset_n,
    input  logic          Start,
    input  logic          InValid,
    output logic          InReady,
    input  logic          InType,
    input  logic [3:0]    InOp,
    input  logic [7:0]    InArg,
    output logic          WrEn,
    output logic [AW-1:0] WrAddr,
    output logic [IW-1:0] WrData,
    output logic          Busy,
    output logic          Done,
    output logic          Error,
    output logic [1:0]    ErrCode,
    output logic [AW:0]   Count
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} stateT;

    // Count value at which memory is full; the next word is an overflow.
    localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_OPERAND = 2'd2;
    localparam logic [1:0] ERR_OVERFL  = 2'd3;

    stateT          state, nextState;
    logic           xfer, accept, isHalt, startLoad;
    logic [1:0]     errDetect;
    logic [IW-1:0]  wordData;

    // NOTE: every always_comb output gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        errDetect = ERR_NONE;
        if (Count == FULL)
            errDetect = ERR_OVERFL;
        else if (!InType && InOp == 4'hF)
            errDetect = ERR_ILLEGAL;
        else if (!InType && InArg[7:4] != 4'h0)
            errDetect = ERR_OPERAND;
    end

    assign wordData  = InType ? {1'b1, InArg} : {1'b0, InOp, InArg[3:0]};
    assign isHalt    = !InType && InOp == 4'hE;
    assign xfer      = InValid && state == LOAD;
    assign accept    = xfer && errDetect == ERR_NONE;
    assign startLoad = Start && state != LOAD;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        InReady   = 1'b0;
        Busy      = 1'b0;
        Done      = 1'b0;
        Error     = 1'b0;
        case (state)
            IDLE, DONE, ERROR: begin
                if (Start)
                    nextState = LOAD;
            end
            LOAD: begin
                if (xfer) begin
                    if (errDetect != ERR_NONE)
                        nextState = ERROR;
                    else if (isHalt)
                        nextState = DONE;
                end
            end
            default: nextState = IDLE;
        endcase
        InReady = (state == LOAD);
        Busy    = (state == LOAD);
        Done    = (state == DONE);
        Error   = (state == ERROR);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            WrEn    <= 1'b0;
            WrAddr  <= '0;
            WrData  <= '0;
            Count   <= '0;
            ErrCode <= ERR_NONE;
        end else begin
            WrEn <= accept;
            if (accept) begin
                WrAddr <= Count[AW-1:0];
                WrData <= wordData;
                Count  <= Count + (AW+1)'(1);
            end
            if (xfer && errDetect != ERR_NONE)
                ErrCode <= errDetect;
            // The write address is the word count, so clearing Count also
            // rewinds the pointer to address 0.
            if (startLoad) begin
                Count   <= '0;
                ErrCode <= ERR_NONE;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader (AW=2): directed loads from the test plan,
// then randomized stimulus compared against a transaction-level reference model.
module tb_prog_loader;

    localparam int IW    = 9;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    // Reference model modes
    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_DONE = 2;
    localparam int M_ERR  = 3;

    logic          CLK = 1'b0;
    logic          Reset_n = 1'b0;
    logic          Start = 1'b0;
    logic          InValid = 1'b0;
    logic          InReady;
    logic          InType = 1'b0;
    logic [3:0]    InOp = 4'h0;
    logic [7:0]    InArg = 8'h00;
    logic          WrEn;
    logic [AW-1:0] WrAddr;
    logic [IW-1:0] WrData;
    logic          Busy, Done, Error;
    logic [1:0]    ErrCode;
    logic [AW:0]   Count;

    prog_loader #(.IW(IW), .AW(AW)) dut (
        .CLK(CLK), .Reset_n(Reset_n), .Start(Start), .InValid(InValid),
        .InReady(InReady), .InType(InType), .InOp(InOp), .InArg(InArg),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .Busy(Busy),
        .Done(Done), .Error(Error), .ErrCode(ErrCode), .Count(Count)
    );

    always #5 CLK = ~CLK;

    int nCmp  = 0;
    int nFail = 0;

    int mMode  = M_IDLE;
    int mCount = 0;
    int mCode  = 0;
    int expWrEn = 0;
    int expAddr = 0;
    int expData = 0;

    task automatic check(input string tag, input int observed, input int expected);
        nCmp++;
        assert (observed === expected)
        else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag);
        check({tag, ".WrEn"}, int'(WrEn), expWrEn);
        if (expWrEn != 0) begin
            check({tag, ".WrAddr"}, int'(WrAddr), expAddr);
            check({tag, ".WrData"}, int'(WrData), expData);
        end
        check({tag, ".InReady"}, int'(InReady), int'(mMode == M_LOAD));
        check({tag, ".Busy"},    int'(Busy),    int'(mMode == M_LOAD));
        check({tag, ".Done"},    int'(Done),    int'(mMode == M_DONE));
        check({tag, ".Error"},   int'(Error),   int'(mMode == M_ERR));
        check({tag, ".ErrCode"}, int'(ErrCode), mCode);
        check({tag, ".Count"},   int'(Count),   mCount);
    endtask

    // One clock cycle: drive inputs, predict the outcome from the loader rules,
    // then compare the DUT just after the rising edge.
    task automatic step(input string tag, input bit st, input bit v, input bit t,
                        input int op, input int arg);
        int code;
        @(negedge CLK);
        Start   = st;
        InValid = v;
        InType  = t;
        InOp    = 4'(op);
        InArg   = 8'(arg);
        expWrEn = 0;
        if (mMode != M_LOAD) begin
            if (st) begin
                mMode  = M_LOAD;
                mCount = 0;
                mCode  = 0;
            end
        end else if (v) begin
            if (mCount == DEPTH)           code = 3;
            else if (!t && op == 15)       code = 1;
            else if (!t && arg >= 16)      code = 2;
            else                           code = 0;
            if (code != 0) begin
                mCode = code;
                mMode = M_ERR;
            end else begin
                expWrEn = 1;
                expAddr = mCount;
                expData = t ? (256 + arg) : (op * 16 + arg % 16);
                mCount++;
                if (!t && op == 14) mMode = M_DONE;
            end
        end
        @(posedge CLK);
        #1;
        checkAll(tag);
    endtask

    task automatic asyncReset(input string tag);
        @(negedge CLK);
        Start = 1'b0;
        InValid = 1'b0;
        #2 Reset_n = 1'b0;
        #1;
        mMode = M_IDLE; mCount = 0; mCode = 0; expWrEn = 0;
        checkAll(tag);
        check({tag, ".WrAddr0"}, int'(WrAddr), 0);
        check({tag, ".WrData0"}, int'(WrData), 0);
        @(negedge CLK);
        Reset_n = 1'b1;
    endtask

    initial begin
        // Power-on reset
        asyncReset("reset");

        // Back-to-back load ending in halt
        step("tp1.start", 1, 0, 0, 0, 0);
        step("tp1.w0", 0, 1, 0, 'h0, 'h03);
        check("tp1.w0.data", int'(WrData), 'h003);
        step("tp1.w1", 0, 1, 0, 'hB, 'h05);
        check("tp1.w1.data", int'(WrData), 'h0B5);
        step("tp1.halt", 0, 1, 0, 'hE, 'h00);
        check("tp1.halt.data", int'(WrData), 'h0E0);
        check("tp1.halt.addr", int'(WrAddr), 2);
        check("tp1.halt.done", int'(Done), 1);
        check("tp1.halt.count", int'(Count), 3);
        step("tp1.ignored", 0, 1, 0, 'h1, 'h01);

        // Branch then halt; branch with 0xE in offset high nibble is not a halt
        step("tp2.start", 1, 0, 0, 0, 0);
        step("tp2.br", 0, 1, 1, 'h0, 'hA7);
        check("tp2.br.data", int'(WrData), 'h1A7);
        step("tp2.brE", 0, 1, 1, 'hE, 'hE0);
        step("tp2.halt", 0, 1, 0, 'hE, 'h00);
        check("tp2.halt.data", int'(WrData), 'h0E0);

        // Illegal opcode as second word, then restart
        step("tp3.start", 1, 0, 0, 0, 0);
        step("tp3.w0", 0, 1, 0, 'h2, 'h04);
        step("tp3.ill", 0, 1, 0, 'hF, 'h01);
        check("tp3.ill.code", int'(ErrCode), 1);
        check("tp3.ill.count", int'(Count), 1);
        step("tp3.restart", 1, 0, 0, 0, 0);
        check("tp3.restart.count", int'(Count), 0);

        // Bad operand
        step("tp4.bad", 0, 1, 0, 'h4, 'h13);
        check("tp4.bad.code", int'(ErrCode), 2);

        // Overflow: four words fill memory, the fifth overflows
        step("tp5.start", 1, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++)
            step("tp5.fill", 0, 1, 0, 'h3, i);
        check("tp5.last.addr", int'(WrAddr), DEPTH - 1);
        step("tp5.ovf", 0, 1, 0, 'h3, 'h09);
        check("tp5.ovf.code", int'(ErrCode), 3);
        check("tp5.ovf.wren", int'(WrEn), 0);

        // Gapped InValid, including Start with InValid in a non-load state
        step("tp6.start", 1, 1, 0, 'h1, 'h01);
        step("tp6.gap", 0, 0, 0, 'h2, 'h02);
        step("tp6.w", 0, 1, 0, 'h3, 'h03);
        step("tp6.gap", 1, 0, 0, 'h4, 'h04);
        step("tp6.w", 0, 1, 1, 'h0, 'h55);
        step("tp6.halt", 1, 1, 0, 'hE, 'h07);

        // Reset in the middle of a load drops the in-flight write
        step("tp7.start", 1, 0, 0, 0, 0);
        step("tp7.w0", 0, 1, 0, 'h1, 'h01);
        step("tp7.w1", 0, 1, 0, 'h2, 'h02);
        asyncReset("tp7.rst");
        step("tp7.restart", 1, 0, 0, 0, 0);
        step("tp7.w0b", 0, 1, 0, 'h5, 'h06);
        check("tp7.w0b.addr", int'(WrAddr), 0);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            int op, arg;
            bit st, v, t;
            st  = ($urandom_range(0, 5) == 0);
            v   = ($urandom_range(0, 2) != 0);
            t   = ($urandom_range(0, 3) == 0);
            op  = $urandom_range(0, 15);
            arg = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15);
            step("rand", st, v, t, op, arg);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Program loader: the writer side of the instruction word that the control decoder reads. It accepts instruction fields (type bit, opcode, operand) over a valid/ready stream and encodes each into a 9-bit instruction word. Words are written to consecutive instruction-memory addresses starting at 0. A load ends on the halt instruction and flags illegal encodings. It sits between the host/testbench program source and instruction memory, ahead of fetch.

Parameters:
IW, 9, instruction word width ({TypeBit, OP[3:0], operand[3:0]} or {TypeBit, offset[7:0]})
AW, 10, instruction memory address width; DEPTH = 2**AW words

Ports:
CLK  in  1  clock, rising edge
Reset_n  in  1  asynchronous, active-low reset
Start  in  1  begin a new load (honoured in IDLE, DONE, ERROR)
InValid  in  1  input fields valid
InReady  out  1  loader can accept; equals (state==LOAD), combinational from state only
InType  in  1  1 = branch instruction, 0 = register/accumulator instruction
InOp  in  4  opcode (ignored when InType=1)
InArg  in  8  branch: 8-bit offset; otherwise register/key in [3:0], [7:4] must be 0
WrEn  out  1  instruction memory write strobe, one cycle per word
WrAddr  out  AW  write address
WrData  out  IW  encoded instruction word
Busy  out  1  state==LOAD
Done  out  1  state==DONE
Error  out  1  state==ERROR
ErrCode  out  2  0 none, 1 illegal opcode, 2 bad operand, 3 overflow
Count  out  AW+1  words written in the current load

Behaviour:
- Reset (Reset_n=0, any time, async): state IDLE. WrEn=0, WrAddr=0, WrData=0, Count=0, ErrCode=0, Done=Busy=Error=0. An in-flight write is dropped.
- States: IDLE, LOAD, DONE, ERROR.
- IDLE/DONE/ERROR + Start=1 -> LOAD next cycle; Count, ErrCode and the next-address pointer clear to 0. Start in LOAD is ignored.
- Transfer: InValid & InReady on a rising edge. At most one word per cycle. Back-to-back transfers are allowed.
- Encoding:
  - InType=1 -> WrData={1'b1, InArg[7:0]}.
  - InType=0 -> WrData={1'b0, InOp, InArg[3:0]}.
- Write latency 1: WrEn, WrAddr, WrData are registered and valid the cycle after the transfer. WrEn is otherwise 0. WrAddr = current pointer. Pointer and Count increment with the write.
- Validation is done at transfer, in this priority order:
  - overflow: Count==DEPTH -> ErrCode 3.
  - illegal opcode: InType=0 & InOp==15 -> ErrCode 1.
  - bad operand: InType=0 & InArg[7:4]!=0 -> ErrCode 2.
  - On any error: no write, next state ERROR, Count holds.
- Halt: a valid word with InType=0 & InOp==14 is written normally, and next state is DONE. WrEn for the halt word coincides with the first DONE cycle. InReady=0 from that cycle on.
- Branch words are never halt, even when InArg[7:4]==14.
- Pointer wrap: the pointer never wraps. The DEPTH-th word (address DEPTH-1) is written; any further word is an overflow.
- DONE/ERROR hold all status outputs until Start or reset.
- Start asserted in the same cycle as a final transfer while in LOAD: Start is ignored.

Test Plan:
- Reset then Start; send (0,0x0,0x03), (0,0xB,0x05), (0,0xE,0x00) back-to-back -> WrData 0x003, 0x0B5, 0x0E0 at WrAddr 0,1,2 on consecutive cycles; Done=1 with halt write; Count=3; InReady=0.
- Branch (1,x,0xA7), then halt -> WrData=0x1A7 at addr 0, 0x0E0 at addr 1; Done=1.
- Illegal (0,0xF,0x01) as 2nd word -> only addr 0 written; Error=1, ErrCode=1, Count=1. Start -> LOAD, Count=0, ErrCode=0.
- Bad operand (0,0x4,0x13) -> no write; ErrCode=2. Overflow with AW=2: 4 non-halt words written to addr 0..3; 5th -> ErrCode=3, no WrEn.
- InValid toggled 1/0 with gaps and during IDLE -> writes occur only on transfers in LOAD, addresses contiguous.
- Reset_n pulled low mid-load after 2 words -> all outputs 0, IDLE; subsequent Start restarts at WrAddr 0.
